axi_noc_wr_master: RTL and testbench

- Network-interface egress block: the master counterpart of the NI's AXI slave interface.
- Consumes packets ejected from the NoC (one header flit followed by payload flits) and replays each packet as a single AXI4 INCR write burst into the attached PE's memory.
- One outstanding write transaction; strict AW -> W -> B ordering.
- Reports write-response errors and dropped flits to the NI status registers.

---
 rtl/axi_noc_wr_master.sv | 145 ++++++++++++++
 tb/tb_axi_noc_wr_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_noc_wr_master.sv
// axi_noc_wr_master
// NoC egress to AXI4 write master. Each ejected packet (one header flit and
// then len+1 payload flits) is replayed as one INCR write burst. Only one
// transaction is outstanding at a time, and the phases run strictly AW, W, B.
//
// Ports:
//   aclk, arstn         clock, asynchronous active-low reset
//   pkt_*               NoC ejection flit stream (valid/ready, head flag, data)
//   aw*                 AXI write-address channel (burst/size/id are constants)
//   w*                  AXI write-data channel, passed straight through from pkt_*
//   b*                  AXI write-response channel
//   busy                high whenever a packet is in flight
//   err_cnt, drop_cnt   saturating counts of bad responses / dropped flits
module axi_noc_wr_master #(
   parameter int               ADDR_W = 32,
   parameter int               DATA_W = 32,
   parameter int               ID_W   = 4,
   parameter logic [ID_W-1:0]  TXN_ID = '0
) (
   input  logic                aclk,
   input  logic                arstn,
   input  logic                pkt_valid,
   output logic                pkt_ready,
   input  logic                pkt_head,
   input  logic [DATA_W-1:0]   pkt_data,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [ID_W-1:0]     awid,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic [ID_W-1:0]     bid,
   output logic                busy,
   output logic [7:0]          err_cnt,
   output logic [7:0]          drop_cnt
);

   localparam int SIZE_I = $clog2(DATA_W/8);

   typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

   state_t            state;
   logic [7:0]        beat_cnt;
   logic [ADDR_W-1:0] hdr_addr;
   logic [7:0]        hdr_len;
   logic              w_fire;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A 32-bit flit has no room for a full address plus a length, so the
   // header packs the length into the low byte and implies 256-byte alignment.
   generate
      if (DATA_W == 32) begin : g_hdr32
         assign hdr_addr = ADDR_W'({pkt_data[31:8], 8'h00});
         assign hdr_len  = pkt_data[7:0];
      end else begin : g_hdr_wide
         assign hdr_addr = pkt_data[ADDR_W-1:0];
         assign hdr_len  = pkt_data[ADDR_W+7:ADDR_W];
      end
   endgenerate

   assign awsize  = SIZE_I[2:0];
   assign awburst = 2'b01;
   assign awid    = TXN_ID;
   assign wstrb   = '1;

   // W phase is a direct pass-through: the flit stream drives the W channel
   // and wready back-pressures the NoC with no buffering in between.
   assign wvalid    = (state == W) && pkt_valid;
   assign wdata     = pkt_data;
   assign wlast     = (state == W) && (beat_cnt == 8'd0);
   assign pkt_ready = (state == IDLE) || ((state == W) && wready);
   assign w_fire    = wvalid && wready;

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state    <= IDLE;
         awvalid  <= 1'b0;
         bready   <= 1'b0;
         busy     <= 1'b0;
         awaddr   <= '0;
         awlen    <= '0;
         beat_cnt <= '0;
         err_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_valid) begin
                  if (pkt_head) begin
                     awaddr   <= hdr_addr;
                     awlen    <= hdr_len;
                     beat_cnt <= hdr_len;
                     awvalid  <= 1'b1;
                     busy     <= 1'b1;
                     state    <= AW;
                  end else begin
                     drop_cnt <= sat_inc(drop_cnt);
                  end
               end
            end
            AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  state   <= W;
               end
            end
            W: begin
               // beat_cnt counts remaining beats down to 0 and is only
               // decremented on non-last beats, so len=255 never wraps.
               if (w_fire) begin
                  if (beat_cnt == 8'd0) begin
                     bready <= 1'b1;
                     state  <= B;
                  end else begin
                     beat_cnt <= beat_cnt - 8'd1;
                  end
               end
            end
            B: begin
               if (bvalid) begin
                  if ((bresp != 2'b00) || (bid != TXN_ID))
                     err_cnt <= sat_inc(err_cnt);
                  bready <= 1'b0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_noc_wr_master.sv
module tb_axi_noc_wr_master;

   logic        aclk = 1'b0;
   logic        arstn;
   logic        pkt_valid, pkt_ready, pkt_head;
   logic [31:0] pkt_data;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awid;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        busy;
   logic [7:0]  err_cnt, drop_cnt;

   axi_noc_wr_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TXN_ID(4'd0)) dut (
      .aclk(aclk), .arstn(arstn),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_head(pkt_head), .pkt_data(pkt_data),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .busy(busy), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // slave knobs
   int         aw_delay = 0;
   int         aw_wait  = 0;
   int         w_stall  = 0;
   logic [1:0] bresp_k  = 2'b00;
   logic [3:0] bid_k    = 4'd0;

   // AXI slave responder: drives just after each rising edge
   initial begin
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
      forever begin
         @(posedge aclk); #1;
         if (aw_delay == 0) awready = 1'b1;
         else if (!awvalid) begin awready = 1'b0; aw_wait = 0; end
         else if (aw_wait < aw_delay) begin awready = 1'b0; aw_wait++; end
         else awready = 1'b1;
         if (busy && !awvalid && !bready && w_stall > 0) begin
            wready = 1'b0; w_stall--;
         end else wready = 1'b1;
         bvalid = bready && arstn;
         bresp  = bresp_k;
         bid    = bid_k;
      end
   end

   // behavioural model: packet-level view of the spec rules
   logic [31:0] exp_wq[$];
   bit          m_busy = 0, m_aw_done = 0, m_w_done = 0;
   int          m_left = 0;
   logic [31:0] m_addr = '0;
   logic [7:0]  m_len = '0;
   int          m_err = 0, m_drop = 0;
   int          aw_cycles = 0, wv_cycles = 0, wstall_cycles = 0, beats = 0, wlast_hs = 0;
   logic [31:0] e;

   always @(negedge aclk) begin
      if (!arstn) begin
         chk("rst_awvalid", awvalid, 0);   chk("rst_wvalid", wvalid, 0);
         chk("rst_wlast", wlast, 0);       chk("rst_bready", bready, 0);
         chk("rst_busy", busy, 0);         chk("rst_pkt_ready", pkt_ready, 1);
         chk("rst_err_cnt", err_cnt, 0);   chk("rst_drop_cnt", drop_cnt, 0);
         chk("rst_awaddr", awaddr, 0);     chk("rst_awlen", awlen, 0);
         m_busy = 0; m_aw_done = 0; m_w_done = 0; m_err = 0; m_drop = 0;
         exp_wq.delete();
      end else begin
         chk("awsize", awsize, 3'd2);   chk("awburst", awburst, 2'b01);
         chk("awid", awid, 4'd0);       chk("wstrb", wstrb, 4'hF);
         chk("err_cnt", err_cnt, m_err); chk("drop_cnt", drop_cnt, m_drop);
         chk("busy", busy, m_busy);
         if (awvalid) aw_cycles++;
         if (wvalid) wv_cycles++;
         if (wvalid && !wready) wstall_cycles++;
         if (!m_busy) begin
            chk("idle_pkt_ready", pkt_ready, 1); chk("idle_awvalid", awvalid, 0);
            chk("idle_wvalid", wvalid, 0);       chk("idle_bready", bready, 0);
            if (pkt_valid) begin
               if (pkt_head) begin
                  m_busy = 1; m_aw_done = 0; m_w_done = 0;
                  m_addr = {pkt_data[31:8], 8'h00};
                  m_len  = pkt_data[7:0];
                  m_left = int'(pkt_data[7:0]);
               end else if (m_drop < 255) m_drop++;
            end
         end else if (!m_aw_done) begin
            chk("aw_awvalid", awvalid, 1);     chk("aw_awaddr", awaddr, m_addr);
            chk("aw_awlen", awlen, m_len);     chk("aw_pkt_ready", pkt_ready, 0);
            chk("aw_wvalid", wvalid, 0);       chk("aw_bready", bready, 0);
            if (awready) m_aw_done = 1;
         end else if (!m_w_done) begin
            chk("w_awvalid", awvalid, 0);      chk("w_bready", bready, 0);
            chk("w_wvalid", wvalid, pkt_valid); chk("w_pkt_ready", pkt_ready, wready);
            chk("w_wlast", wlast, (m_left == 0));
            if (wvalid && wready) begin
               beats++;
               if (wlast) wlast_hs++;
               if (exp_wq.size() == 0) chk("w_unexpected_beat", wdata, 32'hDEAD_BEEF);
               else begin e = exp_wq.pop_front(); chk("w_wdata", wdata, e); end
               if (m_left == 0) m_w_done = 1; else m_left--;
            end
         end else begin
            chk("b_bready", bready, 1);        chk("b_pkt_ready", pkt_ready, 0);
            chk("b_awvalid", awvalid, 0);      chk("b_wvalid", wvalid, 0);
            if (bvalid) begin
               if ((bresp != 2'b00 || bid != 4'd0) && m_err < 255) m_err++;
               m_busy = 0;
            end
         end
      end
   end

   task automatic send_flit(input logic head, input logic [31:0] d);
      int n = 0;
      pkt_valid = 1'b1; pkt_head = head; pkt_data = d;
      @(negedge aclk);
      while (!pkt_ready && n < 2000) begin @(negedge aclk); n++; end
      if (!pkt_ready) chk("flit_accept_timeout", 0, 1);
      @(posedge aclk); #1;
      pkt_valid = 1'b0; pkt_head = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] addr, input logic [7:0] len);
      send_flit(1'b1, {addr[31:8], len});
   endtask

   task automatic send_pay(input logic [31:0] d);
      exp_wq.push_back(d);
      send_flit(1'b0, d);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge aclk);
      while (busy && n < 2000) begin @(negedge aclk); n++; end
      if (busy) chk("idle_timeout", 1, 0);
      @(posedge aclk); #1;
   endtask

   task automatic clr_stats();
      aw_cycles = 0; wv_cycles = 0; wstall_cycles = 0; beats = 0; wlast_hs = 0;
   endtask

   initial begin
      arstn = 1'b0; pkt_valid = 1'b0; pkt_head = 1'b0; pkt_data = '0;
      repeat (3) @(posedge aclk);
      #1 arstn = 1'b1;
      @(posedge aclk); #1;
      chk("init_busy", busy, 0); chk("init_pkt_ready", pkt_ready, 1);

      // basic 4-beat packet
      clr_stats();
      send_hdr(32'h0000_1000, 8'd3);
      for (int i = 0; i < 4; i++) send_pay(32'hA0 + i);
      wait_idle();
      chk("t1_aw_cycles", aw_cycles, 1); chk("t1_beats", beats, 4);
      chk("t1_wlast_hs", wlast_hs, 1);   chk("t1_err_cnt", err_cnt, 0);

      // len=0 with wready stalled 3 cycles
      clr_stats(); w_stall = 3;
      send_hdr(32'h0000_2000, 8'd0);
      send_pay(32'h55);
      wait_idle();
      chk("t2_wv_cycles", wv_cycles, 4); chk("t2_stall_cycles", wstall_cycles, 3);
      chk("t2_wlast_hs", wlast_hs, 1);

      // stray flits in IDLE are dropped
      clr_stats();
      send_flit(1'b0, 32'h11); send_flit(1'b0, 32'h22);
      chk("t3_drop_cnt", drop_cnt, 2);
      send_hdr(32'h0000_3000, 8'd1);
      send_pay(32'hB0); send_pay(32'hB1);
      wait_idle();
      chk("t3_beats", beats, 2); chk("t3_drop_after", drop_cnt, 2);

      // response errors and saturation
      bresp_k = 2'b10;
      send_hdr(32'h0000_4000, 8'd0); send_pay(32'hC0); wait_idle();
      chk("t4_err1", err_cnt, 1);
      bresp_k = 2'b00; bid_k = 4'd1;
      send_hdr(32'h0000_4100, 8'd0); send_pay(32'hC1); wait_idle();
      chk("t4_err2", err_cnt, 2);
      bid_k = 4'd0; bresp_k = 2'b11;
      for (int i = 0; i < 298; i++) begin
         send_hdr(32'h0000_4200, 8'd0); send_pay(i); wait_idle();
      end
      chk("t4_err_sat", err_cnt, 8'hFF);
      bresp_k = 2'b00;

      // 256-beat burst
      clr_stats();
      send_hdr(32'h0000_5000, 8'd255);
      for (int i = 0; i < 256; i++) send_pay(32'h5000_0000 + i);
      wait_idle();
      chk("t5_beats", beats, 256); chk("t5_wlast_hs", wlast_hs, 1);

      // awready delayed 5 cycles
      clr_stats(); aw_delay = 5;
      send_hdr(32'h0000_6000, 8'd1);
      send_pay(32'h60); send_pay(32'h61);
      wait_idle();
      aw_delay = 0;
      chk("t6_aw_cycles", aw_cycles, 6); chk("t6_beats", beats, 2);

      // reset in the middle of the W phase
      clr_stats();
      send_hdr(32'h0000_7000, 8'd4);
      send_pay(32'h70); send_pay(32'h71);
      pkt_valid = 1'b1; pkt_data = 32'h72; arstn = 1'b0;
      @(negedge aclk);
      chk("t7_wvalid_rst", wvalid, 0); chk("t7_busy_rst", busy, 0);
      chk("t7_err_rst", err_cnt, 0);   chk("t7_drop_rst", drop_cnt, 0);
      @(posedge aclk); #1 pkt_valid = 1'b0;
      @(posedge aclk); #1 arstn = 1'b1;
      clr_stats();
      send_hdr(32'h0000_8000, 8'd0); send_pay(32'h99); wait_idle();
      chk("t7_beats_after", beats, 1);

      repeat (3) @(posedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=%0d required=0", 1);
      $fatal(1, "timeout");
   end

endmodule
